// File: rtl/srambank_pkg.sv
// Shared types and configuration for the parametrised SRAM bank.
// SRAMBANK_OUTREG_EN adds a registered output stage, which raises read latency from 1 to 2.
// srambank_cfg_ok() is used by the top-level elaboration check on WORDS/BANKS.
package srambank_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } srambank_state_t;

`ifdef SRAMBANK_OUTREG_EN
  localparam int SRAMBANK_RD_LAT = 2;
`else
  localparam int SRAMBANK_RD_LAT = 1;
`endif

  // Both sizes must be powers of two, and the sub-banks must split the words evenly into >1 row.
  function automatic bit srambank_cfg_ok(input int words, input int banks);
    return (words > 0) && (banks > 1) &&
           ((words & (words - 1)) == 0) &&
           ((banks & (banks - 1)) == 0) &&
           ((words % banks) == 0) && (words > banks);
  endfunction

endpackage

// File: rtl/srambank_array.sv
// One physical sub-bank: ROWS x WIDTH single-port array with bit-masked writes.
// Latency: read data registered, valid one edge after a read with ce=1, we=0.
// No backpressure: every enabled access completes; rd holds until the next read.
module srambank_array #(
  parameter int ROWS  = 256,
  parameter int WIDTH = 34,
  parameter int RW    = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             we,
  input  logic [WIDTH-1:0] wmask,
  input  logic [RW-1:0]    row,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem [ROWS];

  // Masked write: only bits with wmask=1 take the new data.
  always_ff @(posedge clk) begin
    if (ce && we) begin
      mem[row] <= (mem[row] & ~wmask) | (wd & wmask);
    end
  end

  // Read data register; writes leave it untouched so it holds the last read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
    end else if (ce && !we) begin
      rd <= mem[row];
    end
  end

endmodule

// File: rtl/srambank_param.sv
// Parametrised banked SRAM: zero-init sweep after reset, masked writes, read-valid and collision flag.
// Latency: read data/rvalid 1 edge after the request, 2 edges when SRAMBANK_OUTREG_EN is defined.
// Backpressure: ready=0 during the ROWS-edge init sweep (requests dropped); afterwards every access is taken.
module srambank_param
  import srambank_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int WIDTH = 34,
  parameter int BANKS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(WORDS)-1:0] ADDRESS,
  input  logic [WIDTH-1:0]         wd,
  input  logic [WIDTH-1:0]         wmask,
  input  logic                     banksel,
  input  logic                     read,
  input  logic                     write,
  output logic [WIDTH-1:0]         dataout,
  output logic                     rvalid,
  output logic                     ready,
  output logic                     rw_err
);

  localparam int AW   = $clog2(WORDS);
  localparam int BW   = $clog2(BANKS);
  localparam int ROWS = WORDS / BANKS;
  localparam int RW   = AW - BW;

  if (!srambank_cfg_ok(WORDS, BANKS)) begin : g_cfg_err
    $error("srambank_param: WORDS/BANKS must be powers of two with BANKS dividing WORDS");
  end

  srambank_state_t state_q, state_d;
  logic [RW-1:0]   cnt_q;
  logic            init;
  logic [BW-1:0]   bank_a;
  logic [RW-1:0]   row_a;
  logic            acc, acc_wr, acc_rd, collide;
  logic [BW-1:0]   rd_bank_q;
  logic            rvalid_arr_q;
  logic [WIDTH-1:0] bank_rd [BANKS];

  assign bank_a  = ADDRESS[AW-1 -: BW];
  assign row_a   = ADDRESS[RW-1:0];
  assign acc     = ready && banksel && (read || write);
  assign acc_wr  = ready && banksel && write;
  assign acc_rd  = ready && banksel && read && !write;
  assign collide = ready && banksel && read && write;

  // State register for the init sweep / idle FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next state and status: leave INIT once the last row has been cleared.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    init    = 1'b0;
    case (state_q)
      ST_INIT: begin
        init = 1'b1;
        if (cnt_q == RW'(ROWS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: ready = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  // Sweep row counter, restarted by every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (init) cnt_q <= cnt_q + 1'b1;
  end

  // During init all sub-banks write zero to the same row; otherwise only the addressed one is enabled.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    srambank_array #(.ROWS(ROWS), .WIDTH(WIDTH), .RW(RW)) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (init || (acc && (bank_a == BW'(b)))),
      .we    (init || acc_wr),
      .wmask (init ? {WIDTH{1'b1}} : wmask),
      .row   (init ? cnt_q : row_a),
      .wd    (init ? {WIDTH{1'b0}} : wd),
      .rd    (bank_rd[b])
    );
  end

  // Remember which sub-bank the last accepted read went to, plus its valid and collision flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q    <= '0;
      rvalid_arr_q <= 1'b0;
      rw_err       <= 1'b0;
    end else begin
      if (acc_rd) rd_bank_q <= bank_a;
      rvalid_arr_q <= acc_rd;
      rw_err       <= collide;
    end
  end

`ifdef SRAMBANK_OUTREG_EN
  logic [WIDTH-1:0] dout_q;
  logic             rvalid_q;

  // Extra output stage; loads only with fresh read data so dataout still holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (rvalid_arr_q) dout_q <= bank_rd[rd_bank_q];
      rvalid_q <= rvalid_arr_q;
    end
  end

  assign dataout = dout_q;
  assign rvalid  = rvalid_q;
`else
  assign dataout = bank_rd[rd_bank_q];
  assign rvalid  = rvalid_arr_q;
`endif

endmodule

// File: tb/tb_srambank_param.sv
module tb_srambank_param;
  import srambank_pkg::*;

  localparam int L = SRAMBANK_RD_LAT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  ADDRESS = '0;
  logic [33:0] wd = '0;
  logic [33:0] wmask = '0;
  logic        banksel = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [33:0] dataout;
  logic        rvalid;
  logic        ready;
  logic        rw_err;

  int checks = 0;
  int failures = 0;
  bit noisy;

  logic [33:0] vals [4] = '{34'h1_2345_6789, 34'h2_0000_0001, 34'h0_DEAD_BEEF, 34'h3_C3C3_C3C3};
  logic [9:0]  addrs [4] = '{10'h000, 10'h100, 10'h200, 10'h300};

  srambank_param #(.WORDS(1024), .WIDTH(34), .BANKS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ADDRESS (ADDRESS),
    .wd      (wd),
    .wmask   (wmask),
    .banksel (banksel),
    .read    (read),
    .write   (write),
    .dataout (dataout),
    .rvalid  (rvalid),
    .ready   (ready),
    .rw_err  (rw_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    banksel = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [33:0] d, input logic [33:0] m);
    ADDRESS = a; wd = d; wmask = m; banksel = 1'b1; write = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic do_read(input string tag, input logic [9:0] a, input logic [33:0] exp);
    ADDRESS = a; banksel = 1'b1; read = 1'b1;
    tick();
    idle_inputs();
    repeat (L - 1) tick();
    check({tag, "_rvalid"}, rvalid, 1);
    check(tag, dataout, exp);
  endtask

  // Counts edges until ready rises (bounded); also flags any rvalid/rw_err seen meanwhile.
  task automatic wait_ready(input string tag);
    int n = 0;
    noisy = 1'b0;
    while (!ready && n < 400) begin
      tick();
      n++;
      if (rvalid || rw_err) noisy = 1'b1;
    end
    idle_inputs();
    check(tag, n, 256);
    check({tag, "_quiet"}, noisy, 0);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_dataout", dataout, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_ready", ready, 0);
    check("rst_rw_err", rw_err, 0);

    // Release reset mid-cycle with requests (write and collision) hammering during init
    tick();
    #4 rst_n = 1'b1;
    ADDRESS = 10'h3FF; wd = '1; wmask = '1; banksel = 1'b1; read = 1'b1; write = 1'b1;
    wait_ready("init_edges");
    do_read("rd_3ff_zero", 10'h3FF, 34'h0);

    // Bit-masked write
    do_write(10'h105, 34'h3_FFFF_FFFF, '1);
    do_write(10'h105, 34'h0, 34'h0_0000_00FF);
    do_read("mask_105", 10'h105, 34'h3_FFFF_FF00);

    // One word per bank, then back-to-back reads
    for (int i = 0; i < 4; i++) do_write(addrs[i], vals[i], '1);
    for (int i = 0; i < 4 + L - 1; i++) begin
      if (i < 4) begin
        ADDRESS = addrs[i]; banksel = 1'b1; read = 1'b1;
      end else begin
        idle_inputs();
      end
      tick();
      if (i >= L - 1) begin
        check($sformatf("b2b_rvalid%0d", i - L + 1), rvalid, 1);
        check($sformatf("b2b_data%0d", i - L + 1), dataout, vals[i - L + 1]);
      end
    end
    idle_inputs();
    tick();
    check("b2b_rvalid_end", rvalid, 0);
    check("b2b_hold", dataout, vals[3]);

    // Read/write collision
    ADDRESS = 10'h010; wd = 34'h5; wmask = '1; banksel = 1'b1; read = 1'b1; write = 1'b1;
    tick();
    idle_inputs();
    check("coll_rw_err", rw_err, 1);
    check("coll_rvalid", rvalid, 0);
    tick();
    check("coll_rw_err_clr", rw_err, 0);
    check("coll_rvalid2", rvalid, 0);
    check("coll_dataout_hold", dataout, vals[3]);
    do_read("coll_rd_010", 10'h010, 34'h5);

    // Write then immediate read of the same address
    do_write(10'h2AB, 34'h1_5555_AAAA, '1);
    do_read("wr_then_rd", 10'h2AB, 34'h1_5555_AAAA);

    // banksel=0 requests and zero mask leave memory alone
    ADDRESS = 10'h200; wd = '1; wmask = '1; banksel = 1'b0; write = 1'b1;
    tick();
    idle_inputs();
    do_write(10'h300, 34'h0, 34'h0);
    do_read("nosel_wr_200", 10'h200, vals[2]);
    ADDRESS = 10'h000; banksel = 1'b0; read = 1'b1;
    tick();
    idle_inputs();
    check("nosel_rd_rvalid", rvalid, 0);
    tick();
    check("nosel_rd_rvalid2", rvalid, 0);
    check("nosel_rd_hold", dataout, vals[2]);
    do_read("mask0_300", 10'h300, vals[3]);

    // Reset after data written, with a read in flight
    ADDRESS = 10'h100; banksel = 1'b1; read = 1'b1;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rst2_dataout", dataout, 0);
    check("rst2_rvalid", rvalid, 0);
    check("rst2_ready", ready, 0);
    #3 rst_n = 1'b1;

    // Reset again mid-init at row 100
    repeat (100) tick();
    check("midinit_ready", ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst3_ready", ready, 0);
    #2 rst_n = 1'b1;
    wait_ready("reinit_edges");
    do_read("post_rst_105", 10'h105, 34'h0);
    do_read("post_rst_300", 10'h300, 34'h0);
    do_read("post_rst_010", 10'h010, 34'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
